// File: rtl/dot_product_pkg.sv
// Shared types and defaults for the dot-product sequencer.
package dot_product_pkg;

  localparam int DP_DATA_WIDTH   = 8;
  localparam int DP_VECTOR_WIDTH = 4;
  localparam int DP_ADDR_WIDTH   = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    DRAIN    = 3'd2,
    WAIT_RES = 3'd3,
    DONE     = 3'd4
  } dp_state_e;

  // Width of a full-precision sum of vw products of two dw-bit operands.
  function automatic int result_width(input int dw, input int vw);
    return 2 * dw + $clog2(vw);
  endfunction

endpackage

// File: rtl/dot_product_ctrl_valid_delay_line.sv
// Fixed-depth delay for the read strobe so the datapath valid lines up
// with memory output data; 'empty' says no strobe is still in flight.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic empty
);

  logic [DEPTH:1] vld_pipe;

  // shift the strobe one stage per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= din;
      for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dout  = vld_pipe[DEPTH];
  assign empty = ~|vld_pipe;

endmodule

// File: rtl/dot_product_ctrl.sv
// Job sequencer for the dotProduct datapath: issues paired operand reads,
// aligns data_valid to memory latency, waits (bounded) for the result.
module dot_product_ctrl
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH     = DP_DATA_WIDTH,
  parameter int VECTOR_WIDTH   = DP_VECTOR_WIDTH,
  parameter int ADDR_WIDTH     = DP_ADDR_WIDTH,
  parameter int RESULT_WIDTH   = result_width(DATA_WIDTH, VECTOR_WIDTH),
  parameter int MEM_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_a,
  input  logic [ADDR_WIDTH-1:0]   base_b,
  output logic                    ready,
  output logic                    busy,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem1_addr,
  output logic [ADDR_WIDTH-1:0]   mem2_addr,
  output logic                    dp_data_valid,
  input  logic [RESULT_WIDTH-1:0] dp_result,
  input  logic                    dp_result_valid,
  output logic [RESULT_WIDTH-1:0] result,
  output logic                    done,
  output logic                    timeout_err
);

  localparam int IDX_W = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  dp_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_a_q, base_b_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TMO_W-1:0]      tmo_q;
  logic                  accept, capture, tmo_hit, rd_en_d, dly_empty;

  valid_delay_line #(.DEPTH(MEM_LATENCY)) u_vld (
    .clk   (clk),
    .rst   (rst),
    .din   (mem_rd_en),
    .dout  (dp_data_valid),
    .empty (dly_empty)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state and per-cycle control decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_en_d = 1'b0;
    accept  = 1'b0;
    capture = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        accept  = 1'b1;
        idx_d   = '0;
        rd_en_d = 1'b1;
        state_d = READ;
      end
      // the read for idx_q is on the bus now; queue the next or stop
      READ: if (idx_q == LAST_IDX) begin
        state_d = DRAIN;
      end else begin
        idx_d   = idx_q + 1'b1;
        rd_en_d = 1'b1;
      end
      DRAIN: if (dp_result_valid) begin
        capture = 1'b1;
        state_d = DONE;
      end else if (dly_empty) begin
        state_d = WAIT_RES;
      end
      WAIT_RES: if (dp_result_valid) begin
        capture = 1'b1;
        state_d = DONE;
      end else if (tmo_q == TMO_LAST) begin
        tmo_hit = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // read strobe, element index, latched bases and addresses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_en <= 1'b0;
      idx_q     <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      mem1_addr <= '0;
      mem2_addr <= '0;
    end else begin
      mem_rd_en <= rd_en_d;
      idx_q     <= idx_d;
      if (accept) begin
        base_a_q <= base_a;
        base_b_q <= base_b;
      end
      // addresses wrap naturally at 2**ADDR_WIDTH
      if (rd_en_d) begin
        mem1_addr <= (accept ? base_a : base_a_q) + ADDR_WIDTH'(idx_d);
        mem2_addr <= (accept ? base_b : base_b_q) + ADDR_WIDTH'(idx_d);
      end
    end
  end

  // cycles spent in WAIT_RES; restarts from zero every visit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tmo_q <= '0;
    else if (state_q == WAIT_RES) tmo_q <= tmo_q + 1'b1;
    else                        tmo_q <= '0;
  end

  // result capture and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (capture) result <= dp_result;
      if (accept)       timeout_err <= 1'b0;
      else if (tmo_hit) timeout_err <= 1'b1;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = ~ready;
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench: two DUT builds (MEM_LATENCY 1 and 3), each with sync-read memory
// models and a behavioural dot-product datapath; results against a plain sum.
module tb_dot_product_ctrl;
  import dot_product_pkg::*;

  localparam int DW = 8;
  localparam int VW = 4;
  localparam int AW = 5;
  localparam int RW = result_width(DW, VW);
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          sel   = 1'b0;
  logic          mute  = 1'b0;
  logic [AW-1:0] base_a = '0, base_b = '0;
  logic [7:0]    mem1 [32];
  logic [7:0]    mem2 [32];

  int n_chk = 0;
  int n_pass = 0;

  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam bit ME  = (g == 1);
    logic          rdy, bsy, rd_en, dv, dn, terr, dprv;
    logic [AW-1:0] a1, a2;
    logic [RW-1:0] res, dpr, acc;
    logic [7:0]    pa [LAT];
    logic [7:0]    pb [LAT];
    int            cnt;

    dot_product_ctrl #(
      .DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .ADDR_WIDTH(AW),
      .MEM_LATENCY(LAT), .TIMEOUT_CYCLES(TO)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start && (sel == ME)),
      .base_a(base_a), .base_b(base_b),
      .ready(rdy), .busy(bsy), .mem_rd_en(rd_en),
      .mem1_addr(a1), .mem2_addr(a2), .dp_data_valid(dv),
      .dp_result(dpr), .dp_result_valid(dprv),
      .result(res), .done(dn), .timeout_err(terr)
    );

    // sync-read memories with LAT-cycle output pipe, plus accumulating datapath
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        acc  <= '0;
        cnt  <= 0;
        dprv <= 1'b0;
        dpr  <= '0;
      end else begin
        if (rd_en) begin
          pa[0] <= mem1[a1];
          pb[0] <= mem2[a2];
        end
        for (int i = 1; i < LAT; i++) begin
          pa[i] <= pa[i-1];
          pb[i] <= pb[i-1];
        end
        dprv <= 1'b0;
        if (dv) begin
          if (cnt == VW - 1) begin
            dpr  <= acc + RW'(pa[LAT-1]) * RW'(pb[LAT-1]);
            dprv <= !mute;
            acc  <= '0;
            cnt  <= 0;
          end else begin
            acc <= acc + RW'(pa[LAT-1]) * RW'(pb[LAT-1]);
            cnt <= cnt + 1;
          end
        end
      end
    end
  end

  logic          o_rdy, o_busy, o_rd, o_dv, o_done, o_terr;
  logic [AW-1:0] o_a1, o_a2;
  logic [RW-1:0] o_res;

  always_comb begin
    o_rdy  = sel ? g_env[1].rdy  : g_env[0].rdy;
    o_busy = sel ? g_env[1].bsy  : g_env[0].bsy;
    o_rd   = sel ? g_env[1].rd_en : g_env[0].rd_en;
    o_dv   = sel ? g_env[1].dv   : g_env[0].dv;
    o_done = sel ? g_env[1].dn   : g_env[0].dn;
    o_terr = sel ? g_env[1].terr : g_env[0].terr;
    o_a1   = sel ? g_env[1].a1   : g_env[0].a1;
    o_a2   = sel ? g_env[1].a2   : g_env[0].a2;
    o_res  = sel ? g_env[1].res  : g_env[0].res;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic [RW-1:0] ref_dot(input int ba, input int bb);
    int s = 0;
    for (int i = 0; i < VW; i++)
      s += int'(mem1[(ba + i) % 32]) * int'(mem2[(bb + i) % 32]);
    return RW'(s);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      mem1[i] = 8'($urandom);
      mem2[i] = 8'($urandom);
    end
  endtask

  // One job on the selected DUT; checks addresses, read count, done count,
  // result, timeout flag and data_valid lag.
  task automatic run_job(input int ba, input int bb, input bit hold,
                         input bit exp_to, input string tag);
    logic [RW-1:0] exp_res;
    int rd_n = 0, dn_n = 0, cyc = 0, post = 0;
    int last_dv = -1, done_cyc = -1, lag_err = 0, lat;
    logic h[$];
    lat = sel ? 3 : 1;
    exp_res = exp_to ? o_res : ref_dot(ba, bb);
    @(negedge clk);
    base_a = AW'(ba);
    base_b = AW'(bb);
    start  = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk({tag, ".busy"}, 32'(o_busy), 32'd1);
    chk({tag, ".terr_clr"}, 32'(o_terr), 32'd0);
    while (cyc < 400 && post < 4) begin
      if (o_rd) begin
        if (rd_n < VW) begin
          chk({tag, ".a1"}, 32'(o_a1), 32'((ba + rd_n) % 32));
          chk({tag, ".a2"}, 32'(o_a2), 32'((bb + rd_n) % 32));
        end
        rd_n++;
      end
      h.push_back(o_rd);
      if (h.size() > lat && o_dv !== h[h.size() - 1 - lat]) lag_err++;
      if (o_dv) last_dv = cyc;
      if (o_done) begin
        dn_n++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk({tag, ".terr_at_done"}, 32'(o_terr), 32'(exp_to));
          if (hold) start = 1'b0;
        end
      end
      if (done_cyc >= 0) post++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".reads"}, 32'(rd_n), 32'(VW));
    chk({tag, ".dones"}, 32'(dn_n), 32'd1);
    chk({tag, ".result"}, 32'(o_res), 32'(exp_res));
    chk({tag, ".terr_end"}, 32'(o_terr), 32'(exp_to));
    chk({tag, ".dv_lag"}, 32'(lag_err), 32'd0);
    chk({tag, ".ready"}, 32'(o_rdy), 32'd1);
    if (exp_to) chk({tag, ".to_cycles"}, 32'(done_cyc - last_dv), 32'(TO + 2));
  endtask

  initial begin
    int dn_n;
    fill_random();
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(o_rdy), 32'd1);
    chk("rst.busy",  32'(o_busy), 32'd0);
    chk("rst.rd_en", 32'(o_rd), 32'd0);
    chk("rst.done",  32'(o_done), 32'd0);
    chk("rst.terr",  32'(o_terr), 32'd0);
    chk("rst.res",   32'(o_res), 32'd0);
    rst = 1'b0;

    // basic job
    for (int i = 0; i < 4; i++) begin
      mem1[i]     = 8'(i + 1);
      mem2[8 + i] = 8'd1;
    end
    run_job(0, 8, 1'b0, 1'b0, "basic");
    chk("basic.value", 32'(o_res), 32'd10);

    // address wrap
    run_job(30, 31, 1'b0, 1'b0, "wrap");

    // timeout, then next job clears the flag
    mute = 1'b1;
    run_job(4, 12, 1'b0, 1'b1, "tmo");
    mute = 1'b0;
    run_job(2, 5, 1'b0, 1'b0, "after_tmo");

    // start held high through the job
    run_job(7, 19, 1'b1, 1'b0, "hold");

    // reset while the second element is on the bus
    @(negedge clk);
    base_a = 5'd3; base_b = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort.rd_en_pre", 32'(o_rd), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort.ready", 32'(o_rdy), 32'd1);
    chk("abort.busy",  32'(o_busy), 32'd0);
    chk("abort.rd_en", 32'(o_rd), 32'd0);
    chk("abort.a1",    32'(o_a1), 32'd0);
    chk("abort.a2",    32'(o_a2), 32'd0);
    chk("abort.dv",    32'(o_dv), 32'd0);
    chk("abort.res",   32'(o_res), 32'd0);
    chk("abort.done",  32'(o_done), 32'd0);
    chk("abort.terr",  32'(o_terr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dn_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_done) dn_n++;
    end
    chk("abort.no_done", 32'(dn_n), 32'd0);
    for (int i = 0; i < 4; i++) begin
      mem1[16 + i] = 8'd255;
      mem2[20 + i] = 8'd1;
    end
    run_job(16, 20, 1'b0, 1'b0, "max");
    chk("max.value", 32'(o_res), 32'd1020);

    // latency-3 build
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem1[i]     = 8'(i + 1);
      mem2[8 + i] = 8'd1;
    end
    run_job(0, 8, 1'b0, 1'b0, "lat3");
    chk("lat3.value", 32'(o_res), 32'd10);

    // randomized jobs across both builds
    for (int j = 0; j < 6; j++) begin
      fill_random();
      sel = j[0];
      run_job(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              bit'($urandom_range(0, 1)), 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
